window3x3_gen: RTL and testbench
================================

# window3x3_gen

Streaming 3x3 neighbourhood generator that turns a raster-order 8-bit pixel stream into the nine window taps w0..w8 consumed by the median filter. It sits directly upstream of the median stage. It buffers the two previous image rows in internal line buffers and keeps a 3x3 shift register. Each accepted pixel that completes an interior window produces one registered window, presented under a valid/ready handshake.

## Interface
- IMG_WIDTH, 640, pixels per row; legal range is 3 or more.
- IMG_HEIGHT, 480, rows per frame; legal range is 3 or more.
- DATA_W, 8, pixel width in bits.
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_sof  input  1  start of frame, qualified by in_valid. The accepted pixel is forced to position (0,0).
- in_pixel  input  DATA_W  raster-order pixel.
- out_valid  output  1  window taps are valid.
- out_ready  input  1  downstream accepts the window.
- w0..w8  output  DATA_W each  window taps in row-major order. w0 is top-left, w4 is centre, w8 is bottom-right.
- out_last  output  1  marks the final window of the frame.

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. There is a single output register stage, so the block never drops a window.
- Position counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1. They track the position of the next pixel to be accepted.
  - On accept, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At the end of the last row, row wraps to 0.
  - An accept with in_sof set treats that pixel as (0,0). The counters then continue from (1,0), regardless of their previous value.
- Line buffers: two buffers of IMG_WIDTH entries each, indexed by col.
  - On accept, read lb1[col] (row y-1) and lb0[col] (row y-2).
  - Then write lb1[col] <= in_pixel and lb0[col] <= old lb1[col].
- Window shift register:
  - On accept, every row shifts left by one column.
  - The new right column is {lb0[col], lb1[col], in_pixel}, which maps to {w2, w5, w8}.
- Output rule: accepting pixel (x,y) with x>=2 and y>=2 loads the window centred at (x-1,y-1) and sets out_valid.
  - w0 = P(x-2,y-2), w4 = P(x-1,y-1), w8 = P(x,y).
  - Border pixels produce no window. Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- out_last = 1 with the window whose w8 is P(IMG_WIDTH-1, IMG_HEIGHT-1).
- Stale shift-register content left over from the previous row is never emitted, because output requires x>=2.
- Reset values:
  - out_valid=0, out_last=0, w0..w8=0, col=0, row=0.
  - in_ready=1 one cycle after rst deasserts, since out_valid is 0.
  - Line-buffer contents are not cleared. They are don't-care, because rows 0 and 1 are rewritten before they are used.
- Reset mid-frame: the pending window is discarded and the next accepted pixel is (0,0).
- in_sof mid-frame: the partial frame is abandoned. A window already in the output register still completes its handshake normally.
- Arithmetic: counters are $clog2 sized and compare with ==. Pixel data passes through unmodified; there is no arithmetic on the data.

## Timing
- Latency: 1 cycle from accept of P(x,y) to out_valid carrying the window centred at (x-1,y-1).
- Throughput: 1 pixel per cycle while out_ready=1.
- While out_valid && !out_ready:
  - w0..w8, out_last and out_valid are held stable.
  - in_ready=0.
  - Counters, line buffers and the shift register are frozen.
- Simultaneous output handshake and new accept: the output register reloads in the same cycle. If the new pixel is a border pixel, out_valid drops to 0.
- Line buffers may be synchronous-read RAM only if the bypass keeps the 1-cycle latency. Otherwise use registers or asynchronous-read memory.

## Test plan
- **Basic windowing.** IMG_WIDTH=4, IMG_HEIGHT=4, P(x,y)=16*y+x, in_valid=1 and out_ready=1 continuously, in_sof on the first pixel.
  - Expect exactly 4 windows.
  - The first window appears the cycle after accepting 0x22: w0..w8 = 00,01,02,10,11,12,20,21,22.
  - out_last=1 only on the window with w8=0x33.
- **Back-to-back frames.** Send two frames with no idle cycles, using P+0x80 for frame 2. Expect 8 windows. The frame-2 first window has w0=0x80 and w8=0xA2, with no taps mixed in from frame 1.
- **Backpressure.** Hold out_ready=0 for 5 cycles when the first window is presented.
  - w0..w8 stay stable and in_ready=0 throughout.
  - After release, the window sequence is identical to the basic windowing case.
- **Source stalls.** Toggle in_valid randomly, 50% duty. The window values and count must match the basic windowing case.
- **Resync.** Assert in_sof on the pixel at (1,2) of frame 1, then send a full frame. Expect no window between the in_sof pixel and new-frame pixel (2,2), then 4 correct windows.
- **Reset mid-frame.** Assert rst for 1 cycle while out_valid=1.
  - The next cycle shows out_valid=0, out_last=0 and w*=0.
  - A following full frame yields 4 correct windows.

Source files
------------

// File: rtl/window3x3_gen.sv
// window3x3_gen: turns a raster-order pixel stream into 3x3 neighbourhood taps.
// Two line buffers hold the previous two rows. A 3x3 shift register doubles as
// the single output register stage. Only interior windows are flagged valid.
module window3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] w0,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8,
  output logic              out_last
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  pos_x;
  logic [ROW_W-1:0]  pos_y;
  logic              accept;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  // A pixel may enter whenever the output register is empty or being drained.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the pixel being accepted; a start-of-frame pixel is (0,0).
  always_comb begin
    pos_x  = in_sof ? '0 : col_q;
    pos_y  = in_sof ? '0 : row_q;
    lb0_rd = lb0_q[pos_x];
    lb1_rd = lb1_q[pos_x];
  end

  // Advance the raster position of the next expected pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_x == COL_LAST) begin
        col_d = '0;
        row_d = (pos_y == ROW_LAST) ? '0 : pos_y + ROW_W'(1);
      end else begin
        col_d = pos_x + COL_W'(1);
        row_d = pos_y;
      end
    end
  end

  // Shift every window row left and insert the new column {y-2, y-1, y}.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb0_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pixel;
    end
  end

  // Valid only for interior windows; a drained window with no new accept clears.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = (pos_x >= COL_TWO) && (pos_y >= ROW_TWO);
      out_last_d  = (pos_x >= COL_TWO) && (pos_y >= ROW_TWO) &&
                    (pos_x == COL_LAST) && (pos_y == ROW_LAST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Position counters, window taps and handshake state.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_q       <= '{default: '0};
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  // Line buffers age one row per accept; contents need no reset since rows
  // 0 and 1 of every frame are rewritten before any window uses them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[pos_x] <= in_pixel;
      lb0_q[pos_x] <= lb1_rd;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign w0 = win_q[0];
  assign w1 = win_q[1];
  assign w2 = win_q[2];
  assign w3 = win_q[3];
  assign w4 = win_q[4];
  assign w5 = win_q[5];
  assign w6 = win_q[6];
  assign w7 = win_q[7];
  assign w8 = win_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen on a 4x4 image.
module tb_window3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] w [9];

  typedef struct packed {
    logic [71:0] taps;
    logic        last;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   windowsSeen = 0;

  // Hand-computed windows of the 4x4 frame P(x,y)=16*y+x, w0 in the top byte.
  logic [71:0] refTaps [4];
  initial begin
    refTaps[0] = 72'h00_01_02_10_11_12_20_21_22;
    refTaps[1] = 72'h01_02_03_11_12_13_21_22_23;
    refTaps[2] = 72'h10_11_12_20_21_22_30_31_32;
    refTaps[3] = 72'h11_12_13_21_22_23_31_32_33;
  end

  window3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]), .w4(w[4]),
    .w5(w[5]), .w6(w[6]), .w7(w[7]), .w8(w[8]),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] tapsNow();
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};
  endfunction

  function automatic logic [71:0] buildExpected(input int idx, input logic [7:0] base);
    logic [71:0] r;
    r = refTaps[idx];
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = r[k*8 +: 8] + base;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every completed output handshake is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      windowsSeen++;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedWindow: got %h expected no window", tapsNow());
      end else begin
        e = expQ.pop_front();
        checkOutput("windowTaps", tapsNow(), e.taps);
        checkOutput("windowLast", 72'(out_last), 72'(e.last));
      end
    end
  end

  // Offer one pixel and hold it until accepted, with optional idle cycles first.
  task automatic applyStimulus(input logic [7:0] pix, input logic sof, input bit stall);
    bit accepted;
    bit rdy;
    if (stall) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_pixel = pix;
    in_sof   = sof;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      accepted = rdy;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL acceptTimeout: got no accept expected accept of %h", pix);
    end
  endtask

  // Send a whole frame, queuing the expected window for each interior pixel.
  task automatic sendFrame(input logic [7:0] base, input bit stall, input bit useSof);
    exp_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x >= 2 && y >= 2) begin
          e.taps = buildExpected((y - 2) * 2 + (x - 2), base);
          e.last = (x == W - 1) && (y == H - 1);
          expQ.push_back(e);
        end
        applyStimulus(base + 8'(16 * y + x), useSof && x == 0 && y == 0, stall);
      end
    end
  endtask

  // Send the first n pixels of a frame with no windows expected from them.
  task automatic sendPartial(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(base + 8'(16 * (i / W) + (i % W)), i == 0, 1'b0);
  endtask

  // Wait for the scoreboard to empty, then check the window count.
  task automatic waitDrain(input int expectedCount, input string name);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 100 && !drained; i++) begin
      @(posedge clk);
      #2;
      drained = (expQ.size() == 0) && !out_valid;
    end
    if (!drained) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s drain: got %0d pending expected 0", name, expQ.size());
    end
    checkOutput(name, 72'(windowsSeen), 72'(expectedCount));
    expQ.delete();
    windowsSeen = 0;
  endtask

  // Hold out_ready low over the first presented window and check it is frozen.
  task automatic stallCheck();
    bit seen;
    logic [71:0] held;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL stallWindow: got no window expected one");
    end else begin
      held = tapsNow();
      checkOutput("stallFirstTaps", held, refTaps[0]);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checkOutput("stallTapsHeld", tapsNow(), held);
        checkOutput("stallInReady", 72'(in_ready), 72'(0));
        checkOutput("stallValidHeld", 72'(out_valid), 72'(1));
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetValid", 72'(out_valid), 72'(0));
    checkOutput("resetLast", 72'(out_last), 72'(0));
    checkOutput("resetTaps", tapsNow(), 72'h0);
    checkOutput("resetInReady", 72'(in_ready), 72'(1));
    @(posedge clk);
    #1;

    $display("[TB] basic windowing");
    sendFrame(8'h00, 1'b0, 1'b1);
    waitDrain(4, "basicCount");

    $display("[TB] back-to-back frames");
    sendFrame(8'h00, 1'b0, 1'b1);
    sendFrame(8'h80, 1'b0, 1'b1);
    waitDrain(8, "b2bCount");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    fork
      sendFrame(8'h00, 1'b0, 1'b1);
      stallCheck();
    join
    waitDrain(4, "stallCount");

    $display("[TB] source stalls");
    sendFrame(8'h00, 1'b1, 1'b1);
    waitDrain(4, "srcStallCount");

    $display("[TB] resync");
    sendPartial(8'h40, 2 * W + 1);
    sendFrame(8'h00, 1'b0, 1'b1);
    waitDrain(4, "resyncCount");

    $display("[TB] reset mid-frame");
    out_ready = 1'b0;
    sendPartial(8'h40, 2 * W + 3);
    @(negedge clk);
    checkOutput("preResetValid", 72'(out_valid), 72'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midResetValid", 72'(out_valid), 72'(0));
    checkOutput("midResetLast", 72'(out_last), 72'(0));
    checkOutput("midResetTaps", tapsNow(), 72'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sendFrame(8'h00, 1'b0, 1'b0);
    waitDrain(4, "postResetCount");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
